// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared state and direction encodings for the motor controller.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    localparam int c_STATE_W = 3;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_UP    = 3'd1;
    localparam state_t c_ST_DN    = 3'd2;
    localparam state_t c_ST_STOP  = 3'd3;
    localparam state_t c_ST_FAULT = 3'd4;

    localparam logic c_DIR_UP = 1'b1;
    localparam logic c_DIR_DN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/motor_chan.sv
`default_nettype none
// ============================================================================
// Module      : motor_chan
// Description : One motor channel - activate edge detect, up/down FSM with
//               travel timeout, fault latch and post-stop dead time.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_chan
    import motor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DEAD_CYCLES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_activate,
    input  logic                 i_up_limit,
    input  logic                 i_dn_limit,
    input  logic                 i_clear_fault,
    output logic                 o_motor_up_q,
    output logic                 o_motor_dn_q,
    output logic                 o_fault_q,
    output logic [c_STATE_W-1:0] o_state
);

    localparam int c_TMAX = (TIMEOUT_CYCLES > DEAD_CYCLES) ? TIMEOUT_CYCLES : DEAD_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_DEAD_LAST = c_TW'(DEAD_CYCLES - 1);

    state_t          r_state,    w_state;
    logic [c_TW-1:0] r_timer,    w_timer;
    logic            r_last_dir, w_last_dir;
    logic            r_up,       w_up;
    logic            r_dn,       w_dn;
    logic            r_fault,    w_fault;
    logic            r_act_d;
    logic            w_act_rise;
    logic [c_TW-1:0] w_timer_inc;

    assign w_act_rise  = i_activate & ~r_act_d;
    // Saturating increment so a long dwell can never wrap back to zero
    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_timer    <= '0;
            r_last_dir <= c_DIR_DN;
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
            r_fault    <= 1'b0;
            r_act_d    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_last_dir <= w_last_dir;
            r_up       <= w_up;
            r_dn       <= w_dn;
            r_fault    <= w_fault;
            r_act_d    <= i_activate;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_timer    = r_timer;
        w_last_dir = r_last_dir;
        w_up       = r_up;
        w_dn       = r_dn;
        w_fault    = r_fault;
        case (r_state)
            c_ST_IDLE: begin
                w_up = 1'b0;
                w_dn = 1'b0;
                if (w_act_rise) begin
                    w_timer = '0;
                    if (i_up_limit && i_dn_limit) begin
                        w_state = c_ST_FAULT;
                        w_fault = 1'b1;
                    end else if (i_up_limit || (!i_dn_limit && r_last_dir == c_DIR_UP)) begin
                        w_state = c_ST_DN;
                        w_dn    = 1'b1;
                    end else begin
                        w_state = c_ST_UP;
                        w_up    = 1'b1;
                    end
                end
            end
            c_ST_UP: begin
                if (i_up_limit) begin
                    w_state    = c_ST_IDLE;
                    w_up       = 1'b0;
                    w_last_dir = c_DIR_UP;
                    w_timer    = '0;
                end else if (w_act_rise) begin
                    w_state    = c_ST_STOP;
                    w_up       = 1'b0;
                    w_last_dir = c_DIR_UP;
                    w_timer    = '0;
                end else if (r_timer == c_TO_LAST) begin
                    w_state = c_ST_FAULT;
                    w_up    = 1'b0;
                    w_fault = 1'b1;
                end else begin
                    w_timer = w_timer_inc;
                end
            end
            c_ST_DN: begin
                if (i_dn_limit) begin
                    w_state    = c_ST_IDLE;
                    w_dn       = 1'b0;
                    w_last_dir = c_DIR_DN;
                    w_timer    = '0;
                end else if (w_act_rise) begin
                    w_state    = c_ST_STOP;
                    w_dn       = 1'b0;
                    w_last_dir = c_DIR_DN;
                    w_timer    = '0;
                end else if (r_timer == c_TO_LAST) begin
                    w_state = c_ST_FAULT;
                    w_dn    = 1'b0;
                    w_fault = 1'b1;
                end else begin
                    w_timer = w_timer_inc;
                end
            end
            c_ST_STOP: begin
                w_up = 1'b0;
                w_dn = 1'b0;
                if (r_timer == c_DEAD_LAST) begin
                    w_state = c_ST_IDLE;
                    w_timer = '0;
                end else begin
                    w_timer = w_timer_inc;
                end
            end
            c_ST_FAULT: begin
                w_up    = 1'b0;
                w_dn    = 1'b0;
                w_fault = 1'b1;
                // Clearing is refused while both limits report, the wiring is still suspect
                if (i_clear_fault && !(i_up_limit && i_dn_limit)) begin
                    w_state = c_ST_IDLE;
                    w_fault = 1'b0;
                    w_timer = '0;
                end
            end
            default: begin
                w_state = c_ST_IDLE;
                w_up    = 1'b0;
                w_dn    = 1'b0;
                w_fault = 1'b0;
                w_timer = '0;
            end
        endcase
    end

    assign o_motor_up_q = r_up;
    assign o_motor_dn_q = r_dn;
    assign o_fault_q    = r_fault;
    assign o_state      = r_state;

    a_no_both_drive: assert property (@(posedge clk) disable iff (rst) !(r_up && r_dn));

endmodule
`default_nettype wire

// File: rtl/motor_fsm_multi.sv
`default_nettype none
// ============================================================================
// Module      : motor_fsm_multi
// Description : NCH independent up/down motor channels with shared busy flag
//               and packed per-channel state output.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_fsm_multi
    import motor_pkg::*;
#(
    parameter int NCH            = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DEAD_CYCLES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       activate,
    input  logic [NCH-1:0]       up_limit,
    input  logic [NCH-1:0]       dn_limit,
    input  logic [NCH-1:0]       clear_fault,
    output logic [NCH-1:0]       motor_up_q,
    output logic [NCH-1:0]       motor_dn_q,
    output logic [NCH-1:0]       fault_q,
    output logic                 busy,
    output logic [3*NCH-1:0]     control_state
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        motor_chan #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .DEAD_CYCLES    (DEAD_CYCLES)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .i_activate    (activate[i]),
            .i_up_limit    (up_limit[i]),
            .i_dn_limit    (dn_limit[i]),
            .i_clear_fault (clear_fault[i]),
            .o_motor_up_q  (motor_up_q[i]),
            .o_motor_dn_q  (motor_dn_q[i]),
            .o_fault_q     (fault_q[i]),
            .o_state       (control_state[c_STATE_W*i +: c_STATE_W])
        );
    end

    assign busy = |(motor_up_q | motor_dn_q);

endmodule
`default_nettype wire

// File: tb/tb_motor_fsm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_fsm_multi
// Description : Directed-vector scoreboard bench for motor_fsm_multi (2 ch).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_fsm_multi;

    localparam int c_NCH = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [c_NCH-1:0]     activate, up_limit, dn_limit, clear_fault;
    logic [c_NCH-1:0]     motor_up_q, motor_dn_q, fault_q;
    logic                 busy;
    logic [3*c_NCH-1:0]   control_state;

    typedef struct {
        logic [5:0] st;
        logic [1:0] up;
        logic [1:0] dn;
        logic [1:0] flt;
        logic       bsy;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t r_mon;
    int   n_chk  = 0;
    int   n_pass = 0;

    motor_fsm_multi #(
        .NCH            (c_NCH),
        .TIMEOUT_CYCLES (8),
        .DEAD_CYCLES    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .activate      (activate),
        .up_limit      (up_limit),
        .dn_limit      (dn_limit),
        .clear_fault   (clear_fault),
        .motor_up_q    (motor_up_q),
        .motor_dn_q    (motor_dn_q),
        .fault_q       (fault_q),
        .busy          (busy),
        .control_state (control_state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rising edge
    task automatic step(input logic [1:0] a, input logic [1:0] ul, input logic [1:0] dl,
                        input logic [1:0] cf, input logic r,
                        input logic [2:0] s1, input logic [2:0] s0,
                        input logic [1:0] eu, input logic [1:0] ed, input logic [1:0] ef,
                        input string nm);
        exp_t e;
        @(negedge clk);
        activate    = a;
        up_limit    = ul;
        dn_limit    = dl;
        clear_fault = cf;
        rst         = r;
        e.st   = {s1, s0};
        e.up   = eu;
        e.dn   = ed;
        e.flt  = ef;
        e.bsy  = |(eu | ed);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            r_mon = exp_q.pop_front();
            n_chk++;
            if (control_state === r_mon.st && motor_up_q === r_mon.up && motor_dn_q === r_mon.dn &&
                fault_q === r_mon.flt && busy === r_mon.bsy) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got st=%h up=%b dn=%b flt=%b busy=%b, want st=%h up=%b dn=%b flt=%b busy=%b",
                         r_mon.name, control_state, motor_up_q, motor_dn_q, fault_q, busy,
                         r_mon.st, r_mon.up, r_mon.dn, r_mon.flt, r_mon.bsy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        activate = '0; up_limit = '0; dn_limit = '0; clear_fault = '0; rst = 1'b1;
        //   act    ul     dl     cf   rst  s1  s0  up     dn     flt
        step(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, "reset");
        step(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, "first_move_up");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, "up_travel");
        step(2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "up_limit_stop");
        step(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2, 2'b00, 2'b01, 2'b00, "alternate_dn");
        step(2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "dn_limit_stop");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "idle_hold");
        // Manual stop and dead time
        step(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, "up_again");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, "up_again_travel");
        step(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 3, 2'b00, 2'b00, 2'b00, "press_to_stop");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3, 2'b00, 2'b00, 2'b00, "dead_1");
        step(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 3, 2'b00, 2'b00, 2'b00, "dead_2_press_ignored");
        step(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 3, 2'b00, 2'b00, 2'b00, "dead_3_held");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "dead_done_idle");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "idle_after_stop");
        // Travel timeout: dn_limit at the press forces UP
        step(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, "to_start_up");
        for (int k = 1; k <= 7; k++)
            step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, $sformatf("to_travel_%0d", k));
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 4, 2'b00, 2'b00, 2'b01, "timeout_fault");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 4, 2'b00, 2'b00, 2'b01, "fault_latched");
        step(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00, "fault_cleared");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "idle_after_clear");
        // Both limits high
        step(2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 4, 2'b00, 2'b00, 2'b01, "both_limits_fault");
        step(2'b00, 2'b01, 2'b01, 2'b01, 0, 0, 4, 2'b00, 2'b00, 2'b01, "clear_blocked");
        step(2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 4, 2'b00, 2'b00, 2'b01, "fault_no_clear");
        step(2'b00, 2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00, "clear_one_limit");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "idle_after_clear2");
        // Limit and timeout in the same cycle: limit wins
        step(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, "lw_start_up");
        for (int k = 1; k <= 7; k++)
            step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2'b00, $sformatf("lw_travel_%0d", k));
        step(2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "limit_beats_timeout");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "idle_after_lw");
        // Two channels concurrently, then reset mid-travel
        step(2'b11, 2'b10, 2'b01, 2'b00, 0, 2, 1, 2'b01, 2'b10, 2'b00, "dual_start");
        step(2'b11, 2'b00, 2'b00, 2'b00, 0, 2, 1, 2'b01, 2'b10, 2'b00, "dual_travel");
        step(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, "reset_mid_travel");
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "idle_after_reset");

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
